// File: rtl/conv_pkg.sv
// Shared types and constants for the conv/pool window fetcher.
package conv_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DRAIN,
      ISSUE,
      WAIT,
      FDONE
   } fetch_state_t;

   localparam int PIX_W     = 8;
   localparam int WIN       = 4;
   localparam int WIN_BYTES = WIN * WIN;

endpackage

// File: rtl/conv_window_addr_gen.sv
// Maps a (window, slot) pair to an SRAM address, or flags it as zero padding
// when the pixel falls outside the image.
module conv_window_addr_gen
   import conv_pkg::*;
#(
   parameter int IMG_W  = 16,
   parameter int IMG_H  = 16,
   parameter int ADDR_W = 16
) (
   input  logic [15:0]       ox,
   input  logic [15:0]       oy,
   input  logic [3:0]        slot,
   input  logic [ADDR_W-1:0] base_addr,
   output logic              pad,
   output logic [ADDR_W-1:0] mem_addr
);

   localparam logic signed [17:0] W_S = 18'(IMG_W);
   localparam logic signed [17:0] H_S = 18'(IMG_H);

   logic signed [17:0] x;
   logic signed [17:0] y;

   // Window origin sits one pixel up-left of 2*(ox,oy), so coordinates can go negative.
   always_comb begin
      x = $signed({1'b0, ox, 1'b0}) - 18'sd1 + $signed({16'd0, slot[1:0]});
      y = $signed({1'b0, oy, 1'b0}) - 18'sd1 + $signed({16'd0, slot[3:2]});
      pad = (x < 18'sd0) || (x >= W_S) || (y < 18'sd0) || (y >= H_S);
      mem_addr = base_addr + ADDR_W'(y) * ADDR_W'(IMG_W) + ADDR_W'(x);
   end

endmodule

// File: rtl/conv_window_fetch.sv
// Window fetcher: walks an image in SRAM, packs each padded 4x4 stride-2 window
// and hands it to the conv/pool stage, one window per pool_done handshake.
module conv_window_fetch
   import conv_pkg::*;
#(
   parameter int IMG_W  = 16,
   parameter int IMG_H  = 16,
   parameter int ADDR_W = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [ADDR_W-1:0]            base_addr,
   output logic                         mem_re,
   output logic [ADDR_W-1:0]            mem_addr,
   input  logic [7:0]                   mem_rdata,
   input  logic                         pool_done,
   output logic [WIN_BYTES*PIX_W-1:0]   image_4x4,
   output logic                         input_re,
   output logic [15:0]                  input_addr,
   output logic                         busy,
   output logic                         frame_done
);

   localparam logic [15:0] LAST_OX   = 16'(IMG_W / 2 - 1);
   localparam logic [15:0] LAST_OY   = 16'(IMG_H / 2 - 1);
   localparam logic [3:0]  LAST_SLOT = 4'(WIN_BYTES - 1);

   fetch_state_t      state;
   logic [3:0]        slot;
   logic [15:0]       ox;
   logic [15:0]       oy;
   logic [15:0]       win_idx;
   logic [ADDR_W-1:0] base_q;
   logic [ADDR_W-1:0] gen_addr;
   logic              gen_pad;
   logic              cap_valid;
   logic              cap_pad;
   logic [3:0]        cap_slot;

   conv_window_addr_gen #(
      .IMG_W  (IMG_W),
      .IMG_H  (IMG_H),
      .ADDR_W (ADDR_W)
   ) u_addr_gen (
      .ox        (ox),
      .oy        (oy),
      .slot      (slot),
      .base_addr (base_q),
      .pad       (gen_pad),
      .mem_addr  (gen_addr)
   );

   assign win_idx  = oy * 16'(IMG_W / 2) + ox;
   assign mem_re   = (state == FETCH) && !gen_pad;
   assign mem_addr = (state == FETCH) ? gen_addr : '0;

   // SRAM data lags the request by a cycle, so pad/slot ride a one-stage pipe to the capture.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         slot       <= '0;
         ox         <= '0;
         oy         <= '0;
         base_q     <= '0;
         cap_valid  <= 1'b0;
         cap_pad    <= 1'b0;
         cap_slot   <= '0;
         image_4x4  <= '0;
         input_re   <= 1'b0;
         input_addr <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         input_re   <= 1'b0;
         frame_done <= 1'b0;
         cap_valid  <= (state == FETCH);
         cap_pad    <= gen_pad;
         cap_slot   <= slot;
         if (cap_valid)
            image_4x4[{cap_slot, 3'b000} +: PIX_W] <= cap_pad ? 8'h00 : mem_rdata;

         case (state)
            IDLE: begin
               if (start) begin
                  busy   <= 1'b1;
                  base_q <= base_addr;
                  ox     <= '0;
                  oy     <= '0;
                  slot   <= '0;
                  state  <= FETCH;
               end
            end
            FETCH: begin
               slot <= slot + 4'd1;
               if (slot == LAST_SLOT)
                  state <= DRAIN;
            end
            DRAIN: begin
               input_re   <= 1'b1;
               input_addr <= win_idx;
               state      <= ISSUE;
            end
            ISSUE: begin
               state <= WAIT;
            end
            WAIT: begin
               if (pool_done) begin
                  if (ox == LAST_OX && oy == LAST_OY) begin
                     frame_done <= 1'b1;
                     busy       <= 1'b0;
                     state      <= FDONE;
                  end else begin
                     if (ox == LAST_OX) begin
                        ox <= '0;
                        oy <= oy + 16'd1;
                     end else begin
                        ox <= ox + 16'd1;
                     end
                     slot  <= '0;
                     state <= FETCH;
                  end
               end
            end
            FDONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_conv_window_fetch.sv
// Directed bench for conv_window_fetch on a 4x4 image: window contents, latency,
// handshake hold, stray inputs, mid-frame reset and address wrap.
module tb_conv_window_fetch;

   logic         clk;
   logic         rst;
   logic         start;
   logic [15:0]  base_addr;
   logic         mem_re;
   logic [15:0]  mem_addr;
   logic [7:0]   mem_rdata;
   logic         pool_done;
   logic [127:0] image_4x4;
   logic         input_re;
   logic [15:0]  input_addr;
   logic         busy;
   logic         frame_done;

   int checks = 0;
   int fails  = 0;
   logic [15:0] addr_q[$];

   typedef struct {
      logic [15:0]  exp_addr;
      logic [127:0] exp_img;
      int           exp_reads;
      int           stray;
      int           delay;
      logic         check_first;
   } win_vec_t;

   win_vec_t vecs[4];

   conv_window_fetch #(
      .IMG_W  (4),
      .IMG_H  (4),
      .ADDR_W (16)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .base_addr  (base_addr),
      .mem_re     (mem_re),
      .mem_addr   (mem_addr),
      .mem_rdata  (mem_rdata),
      .pool_done  (pool_done),
      .image_4x4  (image_4x4),
      .input_re   (input_re),
      .input_addr (input_addr),
      .busy       (busy),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SRAM model: mem[a] = a[7:0] + 1, one-cycle read latency; junk when not read.
   always @(posedge clk)
      mem_rdata <= mem_re ? (mem_addr[7:0] + 8'd1) : 8'hEE;

   function automatic logic [127:0] packRows(input logic [31:0] r0, input logic [31:0] r1,
                                             input logic [31:0] r2, input logic [31:0] r3);
      logic [31:0]  rows [4];
      logic [127:0] img;
      rows = '{r0, r1, r2, r3};
      img  = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            img[(r*4+c)*8 +: 8] = rows[r][31-8*c -: 8];
      return img;
   endfunction

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Caller raises start or pool_done at a negedge; this counts edges up to input_re.
   task automatic applyStimulus(input int stray, output int cycles, output int reads,
                                output logic first_re);
      bit seen;
      cycles   = 0;
      reads    = 0;
      first_re = 1'b0;
      seen     = 1'b0;
      addr_q.delete();
      for (int n = 0; n < 100 && !seen; n++) begin
         @(posedge clk);
         cycles++;
         @(negedge clk);
         start     = (cycles == stray);
         pool_done = (cycles == stray);
         if (cycles == 1)
            first_re = mem_re;
         if (mem_re) begin
            reads++;
            addr_q.push_back(mem_addr);
         end
         if (input_re)
            seen = 1'b1;
      end
      if (!seen)
         checkOutput("issue_timeout", 128'(cycles), 128'd18);
   endtask

   initial begin
      int       cycles;
      int       reads;
      logic     first_re;
      logic     idle_bad;
      logic [15:0] exp_wrap [9];

      vecs[0] = '{16'd0, packRows(32'h00000000, 32'h00010203, 32'h00050607, 32'h00090A0B),
                  9, -1, 2, 1'b0};
      vecs[1] = '{16'd1, packRows(32'h00000000, 32'h02030400, 32'h06070800, 32'h0A0B0C00),
                  9, 5, 3, 1'b0};
      vecs[2] = '{16'd2, packRows(32'h00050607, 32'h00090A0B, 32'h000D0E0F, 32'h00000000),
                  9, -1, 50, 1'b0};
      vecs[3] = '{16'd3, packRows(32'h06070800, 32'h0A0B0C00, 32'h0E0F1000, 32'h00000000),
                  9, -1, 4, 1'b1};
      exp_wrap = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0002, 16'h0003, 16'h0004,
                   16'h0006, 16'h0007, 16'h0008};

      rst       = 1'b0;
      start     = 1'b0;
      pool_done = 1'b0;
      base_addr = 16'h0100;
      repeat (3) @(negedge clk);
      checkOutput("rst_busy",       128'(busy),       128'd0);
      checkOutput("rst_mem_re",     128'(mem_re),     128'd0);
      checkOutput("rst_mem_addr",   128'(mem_addr),   128'd0);
      checkOutput("rst_input_re",   128'(input_re),   128'd0);
      checkOutput("rst_input_addr", 128'(input_addr), 128'd0);
      checkOutput("rst_image",      image_4x4,        128'd0);
      checkOutput("rst_frame_done", 128'(frame_done), 128'd0);
      rst = 1'b1;
      @(negedge clk);

      // Full frame: window table, stray inputs in window 1, long hold before window 3.
      start = 1'b1;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(vecs[i].stray, cycles, reads, first_re);
         checkOutput($sformatf("w%0d_latency", i), 128'(cycles), 128'd18);
         checkOutput($sformatf("w%0d_index", i), 128'(input_addr), 128'(vecs[i].exp_addr));
         checkOutput($sformatf("w%0d_image", i), image_4x4, vecs[i].exp_img);
         checkOutput($sformatf("w%0d_reads", i), 128'(reads), 128'(vecs[i].exp_reads));
         checkOutput($sformatf("w%0d_busy", i), 128'(busy), 128'd1);
         if (vecs[i].check_first)
            checkOutput($sformatf("w%0d_first_re", i), 128'(first_re), 128'd1);
         idle_bad = 1'b0;
         for (int d = 0; d < vecs[i].delay; d++) begin
            @(negedge clk);
            if (mem_re || input_re || frame_done)
               idle_bad = 1'b1;
         end
         checkOutput($sformatf("w%0d_wait_quiet", i), 128'(idle_bad), 128'd0);
         pool_done = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      pool_done = 1'b0;
      checkOutput("frame_done_pulse", 128'(frame_done), 128'd1);
      checkOutput("frame_busy_low",   128'(busy),       128'd0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checkOutput("frame_done_clear", 128'(frame_done), 128'd0);
      idle_bad = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (busy || mem_re)
            idle_bad = 1'b1;
      end
      checkOutput("fdone_start_ignored", 128'(idle_bad), 128'd0);

      // Reset while fetching slot 7, then replay window 0.
      start  = 1'b1;
      cycles = 0;
      while (cycles < 8) begin
         @(posedge clk);
         cycles++;
         @(negedge clk);
         start = 1'b0;
      end
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checkOutput("abort_busy",       128'(busy),       128'd0);
      checkOutput("abort_mem_re",     128'(mem_re),     128'd0);
      checkOutput("abort_mem_addr",   128'(mem_addr),   128'd0);
      checkOutput("abort_input_re",   128'(input_re),   128'd0);
      checkOutput("abort_input_addr", 128'(input_addr), 128'd0);
      checkOutput("abort_image",      image_4x4,        128'd0);
      checkOutput("abort_frame_done", 128'(frame_done), 128'd0);
      rst = 1'b1;
      idle_bad = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (busy || mem_re)
            idle_bad = 1'b1;
      end
      checkOutput("abort_stays_idle", 128'(idle_bad), 128'd0);
      start = 1'b1;
      applyStimulus(-1, cycles, reads, first_re);
      checkOutput("replay_latency", 128'(cycles),     128'd18);
      checkOutput("replay_index",   128'(input_addr), 128'd0);
      checkOutput("replay_image",   image_4x4,        vecs[0].exp_img);
      checkOutput("replay_reads",   128'(reads),      128'd9);

      // Address wrap near the top of the SRAM.
      rst = 1'b0;
      @(negedge clk);
      rst       = 1'b1;
      base_addr = 16'hFFFE;
      @(negedge clk);
      start = 1'b1;
      applyStimulus(-1, cycles, reads, first_re);
      checkOutput("wrap_reads", 128'(addr_q.size()), 128'd9);
      for (int i = 0; i < 9 && i < addr_q.size(); i++)
         checkOutput($sformatf("wrap_addr%0d", i), 128'(addr_q[i]), 128'(exp_wrap[i]));
      checkOutput("wrap_image", image_4x4,
                  packRows(32'h00000000, 32'h00FF0001, 32'h00030405, 32'h00070809));

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
